// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: decodes BRANCH/JAL/JALR, computes the target,
// and drives the redirect handshake and the flush window.
module branch_resolve #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic              redir_ready_i,
  output logic              redir_valid_o,
  output logic [AWIDTH-1:0] redir_pc_o,
  output logic              flush_o,
  output logic              ex_stall_o,
  output logic              illegal_o,
  output logic              misalign_o,
  output logic [15:0]       br_count_o,
  output logic [15:0]       taken_count_o
);

  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state;
  logic [2:0]        flush_cnt;

  logic [AWIDTH-1:0] imm_ext;
  logic [AWIDTH-1:0] rs1_ext;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic              br_illegal;
  logic              br_cond;
  logic              br_taken;
  logic              taken;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH-1:0] sum;
  logic [AWIDTH-1:0] target;
  logic              misaligned;

  // Immediate is sign-extended when the address is wider than the data path
  generate
    if (DWIDTH >= AWIDTH) begin : g_trunc
      assign imm_ext = imm_i[AWIDTH-1:0];
      assign rs1_ext = rs1_i[AWIDTH-1:0];
    end else begin : g_sext
      assign imm_ext = {{(AWIDTH-DWIDTH){imm_i[DWIDTH-1]}}, imm_i};
      assign rs1_ext = {{(AWIDTH-DWIDTH){1'b0}}, rs1_i};
    end
  endgenerate

  assign is_branch  = (opcode_i == OP_BRANCH);
  assign is_jal     = (opcode_i == OP_JAL);
  assign is_jalr    = (opcode_i == OP_JALR);
  assign br_illegal = is_branch && (funct3_i[2:1] == 2'b01);

  // funct3[2] picks the less-than flag, funct3[0] inverts the sense
  assign br_cond    = funct3_i[2] ? brlt_i : breq_i;
  assign br_taken   = is_branch && !br_illegal && (br_cond ^ funct3_i[0]);
  assign taken      = br_taken || is_jal || is_jalr;

  assign base       = is_jalr ? rs1_ext : pc_i;
  assign sum        = base + imm_ext;
  assign target     = {sum[AWIDTH-1:1], sum[0] & ~is_jalr};
  assign misaligned = target[1];

  assign ex_stall_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      flush_cnt     <= 3'd0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
      flush_o       <= 1'b0;
      illegal_o     <= 1'b0;
      misalign_o    <= 1'b0;
      br_count_o    <= 16'd0;
      taken_count_o <= 16'd0;
    end else begin
      illegal_o  <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid_i) begin
            if (is_branch && br_count_o != 16'hFFFF)
              br_count_o <= br_count_o + 16'd1;
            if (br_taken && taken_count_o != 16'hFFFF)
              taken_count_o <= taken_count_o + 16'd1;
            if (br_illegal)
              illegal_o <= 1'b1;
            if (taken) begin
              if (misaligned) begin
                misalign_o <= 1'b1;
              end else begin
                state         <= REDIRECT;
                redir_valid_o <= 1'b1;
                redir_pc_o    <= target;
              end
            end
          end
        end
        REDIRECT: begin
          if (redir_ready_i) begin
            state         <= FLUSH;
            redir_valid_o <= 1'b0;
            flush_o       <= 1'b1;
            flush_cnt     <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          // Counter starts at FLUSH_CYCLES-1 so flush_o spans exactly FLUSH_CYCLES
          if (flush_cnt == 3'd0) begin
            state   <= IDLE;
            flush_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, reset/hold/saturation
// sequences, and randomized instructions against a transaction-level reference model.
module tb_branch_resolve;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        breq;
  logic        brlt;
  logic        redir_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        flush;
  logic        ex_stall;
  logic        illegal;
  logic        misalign;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  int checks = 0;
  int errors = 0;
  int model_br = 0;
  int model_tk = 0;

  always #5 clk = ~clk;

  branch_resolve #(.DWIDTH(32), .AWIDTH(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .reset(reset),
    .ex_valid_i(ex_valid),
    .opcode_i(opcode),
    .funct3_i(funct3),
    .pc_i(pc),
    .imm_i(imm),
    .rs1_i(rs1),
    .breq_i(breq),
    .brlt_i(brlt),
    .redir_ready_i(redir_ready),
    .redir_valid_o(redir_valid),
    .redir_pc_o(redir_pc),
    .flush_o(flush),
    .ex_stall_o(ex_stall),
    .illegal_o(illegal),
    .misalign_o(misalign),
    .br_count_o(br_count),
    .taken_count_o(taken_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        breq;
    logic        brlt;
  } instr_t;

  typedef struct {
    bit          redir;
    logic [31:0] pc;
    bit          ill;
    bit          mis;
    bit          br_inc;
    bit          tk_inc;
  } expect_t;

  typedef struct {
    string   name;
    instr_t  ins;
    expect_t exp;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] r,
                         input logic eq, input logic lt, input bit rd, input logic [31:0] tpc,
                         input bit il, input bit ms, input bit bi, input bit ti);
    vec_t v;
    v.name = name;
    v.ins.op = op; v.ins.f3 = f3; v.ins.pc = p; v.ins.imm = im; v.ins.rs1 = r;
    v.ins.breq = eq; v.ins.brlt = lt;
    v.exp.redir = rd; v.exp.pc = tpc; v.exp.ill = il; v.exp.mis = ms;
    v.exp.br_inc = bi; v.exp.tk_inc = ti;
    tbl.push_back(v);
  endtask

  // Reference: RISC-V branch semantics computed directly from the instruction rules
  function automatic expect_t ref_model(input instr_t i);
    expect_t e;
    bit tk = 0;
    logic [31:0] t = 32'd0;
    e = '{default: 0};
    case (i.op)
      7'b1100011: begin
        e.br_inc = 1;
        case (i.f3)
          3'd0:       tk = i.breq;
          3'd1:       tk = !i.breq;
          3'd4, 3'd6: tk = i.brlt;
          3'd5, 3'd7: tk = !i.brlt;
          default: begin tk = 0; e.ill = 1; end
        endcase
        e.tk_inc = tk;
        t = i.pc + i.imm;
      end
      7'b1101111: begin tk = 1; t = i.pc + i.imm; end
      7'b1100111: begin tk = 1; t = (i.rs1 + i.imm) & 32'hFFFF_FFFE; end
      default:    begin tk = 0; end
    endcase
    if (tk) begin
      if ((t % 4) >= 2) e.mis = 1;
      else begin e.redir = 1; e.pc = t; end
    end
    return e;
  endfunction

  task automatic drive_instr(input instr_t i);
    opcode = i.op; funct3 = i.f3; pc = i.pc; imm = i.imm; rs1 = i.rs1;
    breq = i.breq; brlt = i.brlt;
  endtask

  task automatic drive_junk();
    ex_valid = 1'b1;
    opcode = ($urandom_range(0, 1) == 1) ? 7'b1100011 : 7'($urandom);
    funct3 = 3'($urandom); pc = $urandom; imm = $urandom; rs1 = $urandom;
    breq = 1'($urandom); brlt = 1'($urandom); redir_ready = 1'($urandom);
  endtask

  task automatic check_counters(input string tag);
    checkOutput({tag, ".br_count"}, br_count, 64'(model_br));
    checkOutput({tag, ".taken_count"}, taken_count, 64'(model_tk));
  endtask

  // Issues one instruction from IDLE and follows it through redirect and flush
  task automatic applyStimulus(input instr_t ins, input expect_t exp, input int delay, input string tag);
    drive_instr(ins);
    ex_valid = 1'b1;
    redir_ready = 1'($urandom);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (exp.br_inc && model_br < 65535) model_br++;
    if (exp.tk_inc && model_tk < 65535) model_tk++;
    checkOutput({tag, ".redir_valid"}, redir_valid, exp.redir);
    checkOutput({tag, ".illegal"}, illegal, exp.ill);
    checkOutput({tag, ".misalign"}, misalign, exp.mis);
    checkOutput({tag, ".stall"}, ex_stall, exp.redir);
    if (exp.redir) begin
      checkOutput({tag, ".redir_pc"}, redir_pc, exp.pc);
      for (int d = 0; d < delay; d++) begin
        drive_junk();
        redir_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, ".hold_valid"}, redir_valid, 1);
        checkOutput({tag, ".hold_pc"}, redir_pc, exp.pc);
        checkOutput({tag, ".hold_stall"}, ex_stall, 1);
        checkOutput({tag, ".hold_flush"}, flush, 0);
      end
      ex_valid = 1'b0;
      redir_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, ".hs_flush"}, flush, 1);
      checkOutput({tag, ".hs_valid"}, redir_valid, 0);
      checkOutput({tag, ".hs_stall"}, ex_stall, 1);
      for (int k = 1; k < FC; k++) begin
        drive_junk();
        @(posedge clk); #1;
        checkOutput({tag, ".flush_on"}, flush, 1);
        checkOutput({tag, ".flush_stall"}, ex_stall, 1);
      end
      drive_junk();
      @(posedge clk); #1;
      ex_valid = 1'b0;
      checkOutput({tag, ".flush_off"}, flush, 0);
      checkOutput({tag, ".idle_stall"}, ex_stall, 0);
      checkOutput({tag, ".idle_valid"}, redir_valid, 0);
    end else begin
      @(posedge clk); #1;
      checkOutput({tag, ".ill_clear"}, illegal, 0);
      checkOutput({tag, ".mis_clear"}, misalign, 0);
      checkOutput({tag, ".no_redir"}, redir_valid, 0);
    end
    check_counters(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_br = 0;
    model_tk = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, ".valid"}, redir_valid, 0);
    checkOutput({tag, ".pc"}, redir_pc, 0);
    checkOutput({tag, ".flush"}, flush, 0);
    checkOutput({tag, ".stall"}, ex_stall, 0);
    checkOutput({tag, ".illegal"}, illegal, 0);
    checkOutput({tag, ".misalign"}, misalign, 0);
    checkOutput({tag, ".br"}, br_count, 0);
    checkOutput({tag, ".tk"}, taken_count, 0);
  endtask

  instr_t  ri;
  expect_t re;

  initial begin
    reset = 1'b1; ex_valid = 1'b0; opcode = '0; funct3 = '0; pc = '0; imm = '0; rs1 = '0;
    breq = 1'b0; brlt = 1'b0; redir_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    //        name         op           f3    pc            imm           rs1          eq lt rd tpc           il ms bi ti
    add_vec("beq_taken",   7'b1100011, 3'd0, 32'h100,      32'h20,       32'h0,       1, 0, 1, 32'h120,     0, 0, 1, 1);
    add_vec("bgeu_nt",     7'b1100011, 3'd7, 32'h100,      32'h20,       32'h0,       0, 1, 0, 32'h0,       0, 0, 1, 0);
    add_vec("jalr_mis",    7'b1100111, 3'd0, 32'h0,        32'h4,        32'h1003,    0, 0, 0, 32'h0,       0, 1, 0, 0);
    add_vec("jalr_ok",     7'b1100111, 3'd0, 32'h0,        32'h4,        32'h1001,    0, 0, 1, 32'h1004,    0, 0, 0, 0);
    add_vec("br_f3_010",   7'b1100011, 3'd2, 32'h100,      32'h20,       32'h0,       1, 1, 0, 32'h0,       1, 0, 1, 0);
    add_vec("br_f3_011",   7'b1100011, 3'd3, 32'h100,      32'h20,       32'h0,       0, 0, 0, 32'h0,       1, 0, 1, 0);
    add_vec("jal_back",    7'b1101111, 3'd0, 32'h2000,     32'hFFFFFFF0, 32'h0,       0, 0, 1, 32'h1FF0,    0, 0, 0, 0);
    add_vec("bne_taken",   7'b1100011, 3'd1, 32'h40,       32'h10,       32'h0,       0, 0, 1, 32'h50,      0, 0, 1, 1);
    add_vec("bne_nt",      7'b1100011, 3'd1, 32'h40,       32'h10,       32'h0,       1, 0, 0, 32'h0,       0, 0, 1, 0);
    add_vec("blt_mis",     7'b1100011, 3'd4, 32'h10,       32'h6,        32'h0,       0, 1, 0, 32'h0,       0, 1, 1, 1);
    add_vec("bge_wrap",    7'b1100011, 3'd5, 32'hFFFFFFF0, 32'h20,       32'h0,       0, 0, 1, 32'h10,      0, 0, 1, 1);
    add_vec("bltu_nt",     7'b1100011, 3'd6, 32'h10,       32'h20,       32'h0,       1, 0, 0, 32'h0,       0, 0, 1, 0);
    add_vec("other_op",    7'b0110011, 3'd0, 32'h10,       32'h20,       32'h0,       1, 1, 0, 32'h0,       0, 0, 0, 0);
    add_vec("jal_mis",     7'b1101111, 3'd0, 32'h100,      32'h2,        32'h0,       0, 0, 0, 32'h0,       0, 1, 0, 0);

    foreach (tbl[n]) applyStimulus(tbl[n].ins, tbl[n].exp, 0, tbl[n].name);

    // BNE taken, fetch not ready for three cycles while EX keeps presenting junk
    applyStimulus(tbl[7].ins, tbl[7].exp, 3, "bne_hold");

    // Reset while a redirect is pending
    drive_instr(tbl[0].ins); ex_valid = 1'b1; redir_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("rst_redir.pre_valid", redir_valid, 1);
    reset = 1'b1; redir_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; model_br = 0; model_tk = 0;
    check_all_zero("rst_redir");
    @(posedge clk); #1;
    checkOutput("rst_redir.no_flush", flush, 0);
    applyStimulus(tbl[0].ins, tbl[0].exp, 1, "after_rst_redir");

    // Reset in the middle of the flush window
    drive_instr(tbl[0].ins); ex_valid = 1'b1; redir_ready = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_flush.pre_flush", flush, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; model_br = 0; model_tk = 0;
    check_all_zero("rst_flush");
    applyStimulus(tbl[7].ins, tbl[7].exp, 0, "after_rst_flush");

    // Randomized instructions against the reference model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    ri.op = 7'b1100011;
        2:       ri.op = 7'b1101111;
        3:       ri.op = 7'b1100111;
        default: ri.op = 7'($urandom);
      endcase
      ri.f3 = 3'($urandom); ri.pc = $urandom; ri.imm = $urandom; ri.rs1 = $urandom;
      ri.breq = 1'($urandom); ri.brlt = 1'($urandom);
      re = ref_model(ri);
      applyStimulus(ri, re, int'($urandom_range(0, 3)), "rand");
    end

    // Saturation: misaligned taken BEQ stays in IDLE and counts every cycle
    do_reset();
    ri = '{op: 7'b1100011, f3: 3'd0, pc: 32'h0, imm: 32'h2, rs1: 32'h0, breq: 1'b1, brlt: 1'b0};
    drive_instr(ri);
    ex_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    ex_valid = 1'b0;
    checkOutput("sat.misalign", misalign, 1);
    checkOutput("sat.stall", ex_stall, 0);
    checkOutput("sat.br_count", br_count, 64'hFFFF);
    checkOutput("sat.taken_count", taken_count, 64'hFFFF);
    model_br = 65535;
    model_tk = 65535;
    applyStimulus(tbl[0].ins, tbl[0].exp, 0, "sat_stick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning operand/immediate width.
REQ-002 SHALL have parameter AWIDTH, default 32, meaning PC width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7, meaning cycles flush_o is held after a redirect is accepted.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the single clock; all state updates on its rising edge.
REQ-005 reset (input, 1): synchronous, active-high reset.
REQ-006 ex_valid_i (input, 1): EX-stage instruction valid.
REQ-007 opcode_i (input, 7) and funct3_i (input, 3): EX-stage instruction fields.
REQ-008 pc_i (input, AWIDTH), imm_i (input, DWIDTH) and rs1_i (input, DWIDTH): instruction PC, sign-extended immediate and rs1 value.
REQ-009 breq_i (input, 1) and brlt_i (input, 1): equal and less-than flags from the branch comparator; for funct3 110/111 brlt_i is the unsigned compare, otherwise signed.
REQ-010 redir_ready_i (input, 1): fetch accepts the redirect.
REQ-011 redir_valid_o (output, 1) and redir_pc_o (output, AWIDTH): redirect request and target.
REQ-012 flush_o (output, 1): squash younger stages. ex_stall_o (output, 1): hold EX.
REQ-013 illegal_o (output, 1) and misalign_o (output, 1): one-cycle exception pulses.
REQ-014 br_count_o (output, 16) and taken_count_o (output, 16): statistics counters.

Function
REQ-015 SHALL decode opcodes BRANCH=1100011, JAL=1101111 and JALR=1100111; other opcodes SHALL be ignored.
REQ-016 Taken rule for BRANCH by funct3: 000 breq; 001 !breq; 100/110 brlt; 101/111 !brlt. JAL and JALR are always taken.
REQ-017 BRANCH with funct3 010 or 011 SHALL be not-taken and SHALL pulse illegal_o on the next cycle.
REQ-018 Target for BRANCH/JAL = pc_i + imm_i; for JALR = (rs1_i + imm_i) with bit0 cleared; addition is modulo 2^AWIDTH (wrap, no overflow flag).
REQ-019 A taken instruction whose target bit1 is set SHALL NOT redirect; it SHALL pulse misalign_o on the next cycle and the FSM SHALL stay IDLE.
REQ-020 FSM states SHALL be IDLE, REDIRECT and FLUSH.
REQ-021 IDLE -> REDIRECT when ex_valid_i and taken and aligned; the target is registered into redir_pc_o at the same edge.
REQ-022 In REDIRECT, redir_valid_o=1 and redir_pc_o SHALL be stable until redir_ready_i=1.
REQ-023 The handshake edge (redir_ready_i=1 in REDIRECT) SHALL move to FLUSH and load the counter with FLUSH_CYCLES-1.
REQ-024 In FLUSH, flush_o=1; the counter decrements each cycle and the FSM SHALL return to IDLE on the edge where the counter is 0, so flush_o is high exactly FLUSH_CYCLES cycles.
REQ-025 ex_stall_o = (state != IDLE), combinationally; ex_valid_i SHALL be ignored outside IDLE (no counting, no exceptions).
REQ-026 redir_ready_i outside REDIRECT SHALL be ignored.
REQ-027 br_count_o SHALL increment for each accepted (IDLE, ex_valid_i) BRANCH opcode, including illegal funct3.
REQ-028 taken_count_o SHALL increment for each accepted taken BRANCH, including misaligned ones; JAL/JALR SHALL NOT count.
REQ-029 Both counters SHALL saturate at 0xFFFF.
REQ-030 Decision latency: redir_valid_o rises exactly 1 cycle after the accepting edge; back-to-back branches are possible 1 cycle after FLUSH exits.

Reset
REQ-031 With reset=1 at a clock edge: state=IDLE, counter=0, redir_valid_o=0, redir_pc_o=0, flush_o=0, illegal_o=0, misalign_o=0, br_count_o=0, taken_count_o=0; ex_stall_o=0 follows.
REQ-032 Reset SHALL override all other inputs, including mid-REDIRECT (redir_valid_o low next cycle, no flush) and mid-FLUSH (flush_o low next cycle).

Verification
REQ-033 BEQ pc=0x100, imm=0x20, breq=1, redir_ready held 1 -> redir_valid_o=1 with 0x120 next cycle, then flush_o high 2 cycles, then IDLE; br=1, taken=1.
REQ-034 BGEU brlt=1 -> no redirect; ex_stall_o stays 0; br=1, taken=0.
REQ-035 JALR rs1=0x1003, imm=0x4 -> target 0x1006 has bit1 set -> misalign_o 1-cycle pulse, no redirect; a second case with rs1=0x1001, imm=0x4 -> redir_pc_o=0x1004.
REQ-036 BNE taken with redir_ready low 3 cycles -> redir_valid_o and redir_pc_o held 3 cycles; new ex_valid_i during the hold ignored; ex_stall_o=1 throughout.
REQ-037 funct3=010 -> illegal_o pulse; separately, 65536+ taken branches -> both counters stick at 0xFFFF.
REQ-038 Reset asserted during REDIRECT and separately during FLUSH -> all outputs 0 next cycle; next branch is handled normally.
